// File: rtl/binary_encoder_arb_pkg.sv
// Shared constants and helpers for the binary encoder / arbiter slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package binary_encoder_arb_pkg;

    // Selection policy codes for the MODE parameter
    localparam int MODE_FIXED = 0;  // lowest index always wins
    localparam int MODE_RR    = 1;  // rotating start point, wraps N-1 -> 0

    // Ceiling log2, used to size the binary index; returns 1 for value <= 2
    // so that the index port is never zero-width.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/binary_encoder_pri.sv
// Combinational N-to-W priority encoder: lowest set bit wins, plus an "any" flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input within the same cycle.
module binary_encoder_pri
    import binary_encoder_arb_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    // Scan from the top down so the last hit written is the lowest set bit
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/binary_encoder_arb.sv
// Picks one active request (fixed priority or round-robin) and registers it as index + one-hot.
// Latency: 1 cycle from captured request to out_valid/idx/onehot.
// Backpressure: one-entry output register; holds while out_valid & ~out_ready, reloads same cycle it drains.
module binary_encoder_arb
    import binary_encoder_arb_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int MODE = MODE_FIXED,
    localparam int W    = clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] req_ack,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0] ptr_q, ptr_d;     // round-robin search start
    logic [W-1:0] idx_q, idx_d;     // held grant, binary
    logic [N-1:0] oh_q,  oh_d;      // held grant, one-hot
    logic         vld_q, vld_d;     // output register occupied

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    logic [W-1:0] u_idx;            // lowest set bit of the full request vector
    logic         u_any;
    logic [W-1:0] m_idx;            // lowest set bit at or above ptr
    logic         m_any;
    logic [W-1:0] win_idx;
    logic [N-1:0] win_oh;
    logic         can_load;

    binary_encoder_pri #(
        .N (N)
    ) u_pri_all (
        .req_i (req),
        .idx_o (u_idx),
        .any_o (u_any)
    );

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [N-1:0] req_masked;

            // Keep only requests at or above the pointer for the first search
            always_comb begin
                req_masked = '0;
                for (int i = 0; i < N; i++) begin
                    req_masked[i] = req[i] & (i >= int'(ptr_q));
                end
            end

            binary_encoder_pri #(
                .N (N)
            ) u_pri_masked (
                .req_i (req_masked),
                .idx_o (m_idx),
                .any_o (m_any)
            );
        end else begin : g_fixed
            // Fixed priority never searches from an offset
            assign m_idx = '0;
            assign m_any = 1'b0;
        end
    endgenerate

    // Prefer the upper (masked) search; fall back to the wrapped full search
    always_comb begin
        win_idx = m_any ? m_idx : u_idx;
        win_oh  = N'(1) << win_idx;
    end

    // A capture happens only with something to take and room in the register.
    // Nothing is acknowledged while reset is asserted, since nothing is captured.
    always_comb begin
        can_load = rst_n & en & u_any & (~vld_q | out_ready);
        req_ack  = can_load ? win_oh : '0;
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------

    // Load on capture, drain on accept without capture, otherwise hold
    always_comb begin
        idx_d = idx_q;
        oh_d  = oh_q;
        vld_d = vld_q;
        if (can_load) begin
            idx_d = win_idx;
            oh_d  = win_oh;
            vld_d = 1'b1;
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    // Pointer moves just past the winner on every load, wrapping at N-1
    always_comb begin
        ptr_d = ptr_q;
        if ((MODE == MODE_RR) && can_load) begin
            if (win_idx == W'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + 1'b1;
            end
        end
    end

    // Registered state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            idx_q <= '0;
            oh_q  <= '0;
            vld_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            idx_q <= idx_d;
            oh_q  <= oh_d;
            vld_q <= vld_d;
        end
    end

    assign out_valid = vld_q;
    assign idx       = idx_q;
    assign onehot    = oh_q;

endmodule

// File: tb/tb_binary_encoder_arb.sv
// Directed bench for binary_encoder_arb: three instances (N=4 fixed, N=4 round-robin, N=5 round-robin).
// Inputs are driven 1 time unit after the rising edge; outputs are checked before the next edge.
// Each scenario task does its own comparisons against hand-computed values.
module tb_binary_encoder_arb;

    logic clk;
    logic rst_n;

    // Instance A: N=4, fixed priority
    logic       en_a, rdy_a, vld_a;
    logic [3:0] req_a, ack_a, oh_a;
    logic [1:0] idx_a;

    // Instance B: N=4, round-robin
    logic       en_b, rdy_b, vld_b;
    logic [3:0] req_b, ack_b, oh_b;
    logic [1:0] idx_b;

    // Instance C: N=5, round-robin, W=3
    logic       en_c, rdy_c, vld_c;
    logic [4:0] req_c, ack_c, oh_c;
    logic [2:0] idx_c;

    int pass_cnt;
    int tot_cnt;

    binary_encoder_arb #(.N(4), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .req(req_a), .req_ack(ack_a),
        .out_valid(vld_a), .out_ready(rdy_a), .idx(idx_a), .onehot(oh_a)
    );

    binary_encoder_arb #(.N(4), .MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .req(req_b), .req_ack(ack_b),
        .out_valid(vld_b), .out_ready(rdy_b), .idx(idx_b), .onehot(oh_b)
    );

    binary_encoder_arb #(.N(5), .MODE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en_c), .req(req_c), .req_ack(ack_c),
        .out_valid(vld_c), .out_ready(rdy_c), .idx(idx_c), .onehot(oh_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en_a = 1'b1; req_a = 4'b1111; rdy_a = 1'b1;
        #1;
        tot_cnt++;
        if (ack_a !== 4'b0000) $display("FAIL reset_ack_in_reset: got %b want 0000", ack_a);
        else pass_cnt++;
        tick(); tick();
        tot_cnt++;
        if (vld_a !== 1'b0) $display("FAIL reset_valid: got %b want 0", vld_a);
        else pass_cnt++;
        tot_cnt++;
        if (idx_a !== 2'd0) $display("FAIL reset_idx: got %0d want 0", idx_a);
        else pass_cnt++;
        tot_cnt++;
        if (oh_a !== 4'b0000) $display("FAIL reset_onehot: got %b want 0000", oh_a);
        else pass_cnt++;
        tot_cnt++;
        if (ack_a !== 4'b0000) $display("FAIL reset_ack: got %b want 0000", ack_a);
        else pass_cnt++;

        // Capture a grant and hold it under backpressure, then reset mid-hold
        rst_n = 1'b1; req_a = 4'b0010; rdy_a = 1'b0;
        tick();
        tot_cnt++;
        if (vld_a !== 1'b1 || idx_a !== 2'd1) $display("FAIL reset_pre_grant: got vld=%b idx=%0d want vld=1 idx=1", vld_a, idx_a);
        else pass_cnt++;
        req_a = 4'b0000; rst_n = 1'b0;
        tick();
        tot_cnt++;
        if (vld_a !== 1'b0 || oh_a !== 4'b0000) $display("FAIL reset_mid_hold: got vld=%b oh=%b want vld=0 oh=0000", vld_a, oh_a);
        else pass_cnt++;
        rst_n = 1'b1; rdy_a = 1'b1;
    endtask

    task automatic test_enable_gate();
        en_a = 1'b0; req_a = 4'b1010; rdy_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tot_cnt++;
            if (ack_a !== 4'b0000) $display("FAIL en_gate_ack[%0d]: got %b want 0000", i, ack_a);
            else pass_cnt++;
            tick();
            tot_cnt++;
            if (vld_a !== 1'b0) $display("FAIL en_gate_valid[%0d]: got %b want 0", i, vld_a);
            else pass_cnt++;
        end
        en_a = 1'b1;
        #1;
        tot_cnt++;
        if (ack_a !== 4'b0010) $display("FAIL en_open_ack: got %b want 0010", ack_a);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (vld_a !== 1'b1 || idx_a !== 2'd1 || oh_a !== 4'b0010)
            $display("FAIL en_open_grant: got vld=%b idx=%0d oh=%b want vld=1 idx=1 oh=0010", vld_a, idx_a, oh_a);
        else pass_cnt++;
        // Drain: accepted with nothing new to capture
        req_a = 4'b0000;
        tick();
        tot_cnt++;
        if (vld_a !== 1'b0) $display("FAIL drain_valid: got %b want 0", vld_a);
        else pass_cnt++;
    endtask

    task automatic test_fixed_priority();
        en_a = 1'b1; rdy_a = 1'b1; req_a = 4'b1100;
        for (int i = 0; i < 3; i++) begin
            #1;
            tot_cnt++;
            if (ack_a !== 4'b0100) $display("FAIL fixed_ack[%0d]: got %b want 0100", i, ack_a);
            else pass_cnt++;
            tick();
            tot_cnt++;
            if (vld_a !== 1'b1 || idx_a !== 2'd2 || oh_a !== 4'b0100)
                $display("FAIL fixed_grant[%0d]: got vld=%b idx=%0d oh=%b want vld=1 idx=2 oh=0100", i, vld_a, idx_a, oh_a);
            else pass_cnt++;
        end
        req_a = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        int         seq_all [5] = '{0, 1, 2, 3, 0};
        int         seq_pair[4] = '{0, 3, 0, 3};
        logic [3:0] e_oh;
        en_b = 1'b1; rdy_b = 1'b1; req_b = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            e_oh = 4'b0001 << seq_all[i];
            tot_cnt++;
            if (vld_b !== 1'b1 || idx_b !== 2'(seq_all[i]) || oh_b !== e_oh)
                $display("FAIL rr_all[%0d]: got vld=%b idx=%0d oh=%b want vld=1 idx=%0d oh=%b", i, vld_b, idx_b, oh_b, seq_all[i], e_oh);
            else pass_cnt++;
        end
        // The sweep leaves ptr at 1; a reset returns it to 0 so the pair sequence starts at source 0
        req_b = 4'b0000; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; req_b = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick();
            e_oh = 4'b0001 << seq_pair[i];
            tot_cnt++;
            if (vld_b !== 1'b1 || idx_b !== 2'(seq_pair[i]) || oh_b !== e_oh)
                $display("FAIL rr_pair[%0d]: got vld=%b idx=%0d oh=%b want vld=1 idx=%0d oh=%b", i, vld_b, idx_b, oh_b, seq_pair[i], e_oh);
            else pass_cnt++;
        end
        req_b = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        en_a = 1'b1; rdy_a = 1'b1; req_a = 4'b0100;
        tick();
        tot_cnt++;
        if (vld_a !== 1'b1 || idx_a !== 2'd2) $display("FAIL bp_setup: got vld=%b idx=%0d want vld=1 idx=2", vld_a, idx_a);
        else pass_cnt++;
        rdy_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_a = (i % 2 == 0) ? 4'b0001 : 4'b1000;
            #1;
            tot_cnt++;
            if (ack_a !== 4'b0000) $display("FAIL bp_ack[%0d]: got %b want 0000", i, ack_a);
            else pass_cnt++;
            tick();
            tot_cnt++;
            if (vld_a !== 1'b1 || idx_a !== 2'd2 || oh_a !== 4'b0100)
                $display("FAIL bp_hold[%0d]: got vld=%b idx=%0d oh=%b want vld=1 idx=2 oh=0100", i, vld_a, idx_a, oh_a);
            else pass_cnt++;
        end
        rdy_a = 1'b1; req_a = 4'b0001;
        #1;
        tot_cnt++;
        if (ack_a !== 4'b0001) $display("FAIL bp_release_ack: got %b want 0001", ack_a);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (vld_a !== 1'b1 || idx_a !== 2'd0 || oh_a !== 4'b0001)
            $display("FAIL bp_release_grant: got vld=%b idx=%0d oh=%b want vld=1 idx=0 oh=0001", vld_a, idx_a, oh_a);
        else pass_cnt++;
        req_a = 4'b0000;
        tick();
    endtask

    task automatic test_non_pow2();
        int         seq[3] = '{0, 4, 0};
        logic [4:0] e_oh;
        en_c = 1'b1; rdy_c = 1'b1; req_c = 5'b10001;
        for (int i = 0; i < 3; i++) begin
            tick();
            e_oh = 5'b00001 << seq[i];
            tot_cnt++;
            if (vld_c !== 1'b1 || idx_c !== 3'(seq[i]) || oh_c !== e_oh)
                $display("FAIL np2_grant[%0d]: got vld=%b idx=%0d oh=%b want vld=1 idx=%0d oh=%b", i, vld_c, idx_c, oh_c, seq[i], e_oh);
            else pass_cnt++;
            tot_cnt++;
            if (idx_c > 3'd4) $display("FAIL np2_idx_range[%0d]: got %0d want <=4", i, idx_c);
            else pass_cnt++;
        end
        req_c = 5'b00000;
        tick();
        tot_cnt++;
        if (vld_c !== 1'b0) $display("FAIL np2_drain: got %b want 0", vld_c);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        tot_cnt  = 0;
        rst_n = 1'b0;
        en_a = 1'b0; req_a = '0; rdy_a = 1'b0;
        en_b = 1'b0; req_b = '0; rdy_b = 1'b0;
        en_c = 1'b0; req_c = '0; rdy_c = 1'b0;
        tick();

        test_reset();
        test_enable_gate();
        test_fixed_priority();
        test_round_robin();
        test_backpressure();
        test_non_pow2();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
